// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads over a req/ack
// handshake and buffers PC-tagged instructions in a small FIFO ahead of IF/ID.
module fetch_queue #(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE = (AW + 1)'(1'b1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1'b1);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(3'd4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [XLEN-1:0]    fetch_pc_r;
    logic [XLEN-1:0]    drop_addr_r;
    logic [AW-1:0]      head_r;
    logic [AW-1:0]      tail_r;
    logic [AW:0]        count_r;
    logic [31:0]        mem_instr_r [DEPTH];
    logic [XLEN-1:0]    mem_pc_r    [DEPTH];

    logic               room_s;
    logic               req_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               nonempty_s;
    logic [XLEN-1:0]    target_s;

    assign room_s     = (count_r < DEPTH_C);
    assign nonempty_s = (count_r != {(AW + 1){1'b0}});
    assign target_s   = {redirect_pc[XLEN-1:2], 2'b00};

    // Request qualification: a new fetch starts only with room and no flush pending
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            ST_IDLE: req_s = room_s && !redirect_valid;
            ST_WAIT: req_s = 1'b1;
            ST_DROP: req_s = 1'b1;
            default: req_s = 1'b0;
        endcase
    end

    assign imem_req  = req_s && !rst;
    assign imem_addr = (state_r == ST_DROP) ? drop_addr_r : fetch_pc_r;
    assign accept_s  = req_s && imem_ack && !rst;
    // A drop-state ack returns data for a flushed path, so it never reaches the FIFO
    assign push_s    = accept_s && !redirect_valid && (state_r != ST_DROP);
    assign pop_s     = nonempty_s && out_ready && !redirect_valid;

    assign out_valid = nonempty_s && !rst;
    assign out_instr = mem_instr_r[head_r];
    assign out_pc    = mem_pc_r[head_r];

    // Next-state selection for the outstanding-request tracker
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid) begin
                    state_nxt_s = ST_IDLE;
                end else if (req_s && !imem_ack) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else if (redirect_valid) begin
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state: FSM, fetch PC, FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            fetch_pc_r  <= RESET_PC;
            drop_addr_r <= RESET_PC;
            head_r      <= {AW{1'b0}};
            tail_r      <= {AW{1'b0}};
            count_r     <= {(AW + 1){1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (redirect_valid) begin
                fetch_pc_r <= target_s;
                head_r     <= {AW{1'b0}};
                tail_r     <= {AW{1'b0}};
                count_r    <= {(AW + 1){1'b0}};
            end else begin
                if (push_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                    tail_r     <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
            // Keep presenting the abandoned address until the memory acks it
            if ((state_r == ST_WAIT) && redirect_valid && !imem_ack) begin
                drop_addr_r <= fetch_pc_r;
            end
        end
    end

    // FIFO storage write; contents need no reset since out_valid gates them
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_instr_r[tail_r] <= imem_rdata;
            mem_pc_r[tail_r]    <= fetch_pc_r;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: transaction-level model (PC queue plus one
// outstanding-request record) driven by directed phases and randomized traffic.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [63:0] q[$];
    logic [63:0] m_pc = 64'h0;
    logic [63:0] m_addr = 64'h0;
    logic        m_pend = 1'b0;
    logic        m_stale = 1'b0;
    int          wcnt = 0;
    int          lat = 0;
    bit          rand_lat = 1'b0;
    logic        last_req, last_ack;
    logic [63:0] last_addr;
    bit          watch20 = 1'b0;
    int          n_bad20 = 0;
    bit          found;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf ^ a[63:32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rdy, input logic redir, input logic [63:0] tgt, input logic rs);
        logic        exp_req, acked, pop;
        logic [63:0] exp_addr;
        rst = rs; out_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
        if (rs) exp_req = 1'b0;
        else if (m_pend) exp_req = 1'b1;
        else exp_req = (q.size() < DEPTH) && !redir;
        exp_addr = m_pend ? m_addr : m_pc;
        acked = exp_req && (wcnt >= lat);
        imem_ack = acked;
        imem_rdata = mem_word(exp_addr);
        @(negedge clk);
        chk("out_valid", out_valid, !rs && (q.size() != 0));
        if (!rs && q.size() != 0) begin
            chk("out_pc", out_pc, q[0]);
            chk("out_instr", out_instr, mem_word(q[0]));
        end
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        if (watch20 && !rs && out_valid && rdy && !redir && out_pc == 64'h20) n_bad20++;
        @(posedge clk);
        if (rs) begin
            q.delete(); m_pc = 64'h0; m_pend = 1'b0; m_stale = 1'b0; wcnt = 0;
        end else begin
            pop = (q.size() != 0) && rdy && !redir;
            if (acked || !exp_req) wcnt = 0; else wcnt++;
            if (redir) begin
                q.delete();
                m_pc = {tgt[63:2], 2'b00};
                if (acked) begin m_pend = 1'b0; m_stale = 1'b0; end
                else if (m_pend) m_stale = 1'b1;
            end else begin
                if (pop) void'(q.pop_front());
                if (acked) begin
                    if (!m_stale) begin q.push_back(exp_addr); m_pc = m_pc + 64'd4; end
                    m_pend = 1'b0; m_stale = 1'b0;
                end else if (exp_req) begin
                    m_pend = 1'b1; m_addr = exp_addr;
                end
            end
            if (acked && rand_lat) lat = $urandom_range(0, 3);
        end
        #1;
        last_req = exp_req; last_addr = exp_addr; last_ack = acked;
    endtask

    initial begin
        @(posedge clk); #1;
        // reset, then streaming with a zero-wait memory
        repeat (2) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        lat = 0;
        repeat (10) cycle(1'b1, 1'b0, 64'h0, 1'b0);
        // back-pressure fills the FIFO, then drains in order
        repeat (8) cycle(1'b0, 1'b0, 64'h0, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 64'h0, 1'b0);

        // latency-3 memory, redirect one cycle after the request at 0x20
        repeat (2) cycle(1'b1, 1'b0, 64'h0, 1'b1);
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cycle(1'b1, 1'b0, 64'h0, 1'b0);
            if (last_req && last_addr == 64'h20 && !last_ack) begin found = 1'b1; break; end
        end
        chk("reach_req_0x20", found, 1'b1);
        watch20 = 1'b1;
        cycle(1'b1, 1'b1, 64'h103, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 64'h0, 1'b0);
        watch20 = 1'b0;
        chk("no_entry_0x20", n_bad20, 64'd0);

        // redirect coinciding with an ack and a pop, two entries queued
        lat = 0;
        cycle(1'b1, 1'b1, 64'h300, 1'b0);
        for (int i = 0; i < 10 && q.size() < 2; i++) cycle(1'b0, 1'b0, 64'h0, 1'b0);
        lat = 1;
        cycle(1'b0, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b1, 64'h5a7, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 64'h0, 1'b0);

        // randomized traffic: variable latency, ready toggling, occasional redirects
        rand_lat = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
                  {$urandom, $urandom}, 1'b0);
        end
        rand_lat = 1'b0;

        // reset while a request is outstanding and three entries are queued
        lat = 0;
        cycle(1'b0, 1'b1, 64'h400, 1'b0);
        for (int i = 0; i < 20 && q.size() < 3; i++) cycle(1'b0, 1'b0, 64'h0, 1'b0);
        lat = 3;
        cycle(1'b0, 1'b0, 64'h0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        lat = 0;
        repeat (10) cycle(1'b1, 1'b0, 64'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned instructions, tagged with their PC, are buffered in a DEPTH-entry FIFO. The head entry is presented to IF/ID with a valid/ready handshake. A taken-branch redirect from ID flushes the FIFO and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
XLEN, 64, PC width.
RESET_PC, 64'h0, first fetch address after reset; must be 4-aligned.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
redirect_valid  in  1  taken branch in ID (the and_branch term)
redirect_pc  in  XLEN  branch target; bits [1:0] ignored, treated as 0
out_ready  in  1  IF/ID can accept (top ties to ~stall)
out_valid  out  1  head entry valid
out_instr  out  32  head instruction
out_pc  out  XLEN  head instruction PC
imem_req  out  1  read request
imem_addr  out  XLEN  byte address, 4-aligned
imem_ack  in  1  one-cycle pulse; imem_rdata valid in this cycle
imem_rdata  in  32  instruction word

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=RESET_PC, count=0, head=tail=0, state=IDLE. While rst is high: out_valid=0, imem_req=0.
- rst overrides every other input, including mid-WAIT/DROP. Any ack for the abandoned request is the memory's concern; after reset the block ignores acks while in IDLE with imem_req=0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request issued in an earlier cycle, ack not yet received.
  - DROP: outstanding request has been invalidated by a redirect.
- room = (registered count < DEPTH). A pop in the same cycle is not credited.
- imem_req (combinational):
  - IDLE: room && !redirect_valid.
  - WAIT, DROP: 1.
- imem_addr: fetch_pc in IDLE/WAIT; drop_addr register in DROP. Address and req stay stable from first assertion until ack.
- Ack with imem_req=1 in IDLE/WAIT, no redirect: push {fetch_pc, imem_rdata} at tail; fetch_pc += 4 (wraps mod 2^XLEN); next state IDLE. Zero-wait memory therefore gives 1 instruction/cycle.
- imem_req=1 without ack: IDLE -> WAIT; WAIT stays WAIT.
- redirect_valid=1 (any state):
  - Flush FIFO: count=0, head=tail=0.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - Next state:
    - IDLE -> IDLE.
    - WAIT with ack -> IDLE; data discarded.
    - WAIT without ack -> DROP; drop_addr captures the old fetch_pc.
    - DROP with ack -> IDLE.
    - DROP without ack -> DROP.
- DROP without redirect: ack -> IDLE, data discarded, no push. fetch_pc is untouched.
- Pop: out_valid && out_ready && !redirect_valid -> head++ (wraps mod DEPTH), count--. Redirect overrides pop.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Overflow is impossible by construction. Popping an empty FIFO is ignored.
- out_valid = (count != 0). out_instr/out_pc are read combinationally from storage[head]. Contents are undefined when out_valid=0.
- Latency:
  - IDLE issue with ack in the same cycle -> out_valid next cycle.
  - Redirect at edge N -> imem_req for the target at cycle N+1 (IDLE/WAIT-with-ack) or the cycle after the drop ack.
  - The first flushed-target instruction is visible one cycle after its ack.

Test Plan:
- Reset release, ack tied high, out_ready=1 -> imem_addr 0x0,0x4,0x8… on consecutive cycles; out_pc follows one cycle later; one instruction/cycle.
- out_ready=0, zero-wait memory, DEPTH=4 -> exactly 4 acks, then imem_req=0. Raise out_ready -> 4 pops in order (PC 0x0..0xC), fetch resumes at 0x10.
- Memory latency 3, redirect to 0x103 one cycle after req at 0x20 -> enter DROP, imem_addr holds 0x20 until ack, data discarded. Next req at 0x100; no entry with PC 0x20 ever appears.
- Redirect in the same cycle as ack and as out_ready=1 with 2 entries queued -> count=0 next cycle, no push, next imem_addr=target.
- Sustained push/pop with out_ready toggled pseudo-randomly over 50 instructions -> pointer wrap. Scoreboard: strictly sequential PCs, no loss or duplication.
- rst asserted while in WAIT with 3 entries queued -> next cycle out_valid=0 and imem_req=0 (rst held). After release, fetch restarts at RESET_PC.
